// File: rtl/mbist_compare_log_if.sv
// Compare-log session and compare-request bundle. The master side drives the
// session control and compare request; the slave side is the compare logger.
interface mbist_compare_log_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
);
   logic              start_i;
   logic              end_i;
   logic              cmp_valid_i;
   logic [ADDR_W-1:0] cmp_addr_i;
   logic [DATA_W-1:0] data_comp_i;
   logic [DATA_W-1:0] exp_data_i;
   logic [DATA_W-1:0] mask_i;
   logic              result_o;
   logic              result_valid_o;
   logic              fail_o;
   logic [CNT_W-1:0]  fail_cnt_o;
   logic              first_valid_o;
   logic [ADDR_W-1:0] first_addr_o;
   logic [DATA_W-1:0] first_syn_o;
   logic              busy_o;
   logic              done_o;

   modport master (
      output start_i, end_i, cmp_valid_i, cmp_addr_i, data_comp_i, exp_data_i, mask_i,
      input  result_o, result_valid_o, fail_o, fail_cnt_o, first_valid_o,
             first_addr_o, first_syn_o, busy_o, done_o
   );

   modport slave (
      input  start_i, end_i, cmp_valid_i, cmp_addr_i, data_comp_i, exp_data_i, mask_i,
      output result_o, result_valid_o, fail_o, fail_cnt_o, first_valid_o,
             first_addr_o, first_syn_o, busy_o, done_o
   );
endinterface

// File: rtl/mbist_compare_log.sv
// MBIST compare logger: two-stage masked compare pipeline with a sticky fail
// flag, saturating fail counter and first-fail address/syndrome capture.
//
// state | meaning
// IDLE  | no session yet, compares ignored
// RUN   | session open, compares accepted
// DRAIN | session closed, last accepted compare completing
// DONE  | session closed, log held until next start
module mbist_compare_log #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                clk_i,
   input  logic                reset_i,
   mbist_compare_log_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              s1_valid_q;
   logic [ADDR_W-1:0] s1_addr_q;
   logic [DATA_W-1:0] s1_syn_q;
   logic              result_q, result_valid_q;
   logic              fail_q;
   logic [CNT_W-1:0]  fail_cnt_q;
   logic              first_valid_q;
   logic [ADDR_W-1:0] first_addr_q;
   logic [DATA_W-1:0] first_syn_q;
   logic              busy_q, done_q;

   logic              accept;
   logic              s2_fail;
   logic [DATA_W-1:0] syn_in;

   assign syn_in  = (bus.data_comp_i ^ bus.exp_data_i) & bus.mask_i;
   assign accept  = (state_q == S_RUN) && bus.cmp_valid_i && !bus.start_i;
   assign s2_fail = s1_valid_q && (s1_syn_q != '0);

   // Next-state: start wins from any state, including over a coincident end.
   always_comb begin
      state_d = state_q;
      if (bus.start_i) begin
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN:   if (bus.end_i) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            default: state_d = state_q;
         endcase
      end
   end

   // State, compare pipeline and fail log; start flushes in-flight compares.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= S_IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_addr_q      <= '0;
         s1_syn_q       <= '0;
         result_q       <= 1'b0;
         result_valid_q <= 1'b0;
         fail_q         <= 1'b0;
         fail_cnt_q     <= '0;
         first_valid_q  <= 1'b0;
         first_addr_q   <= '0;
         first_syn_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done_q  <= (state_d == S_DONE);
         if (bus.start_i) begin
            s1_valid_q     <= 1'b0;
            result_valid_q <= 1'b0;
            fail_q         <= 1'b0;
            fail_cnt_q     <= '0;
            first_valid_q  <= 1'b0;
            first_addr_q   <= '0;
            first_syn_q    <= '0;
         end else begin
            s1_valid_q <= accept;
            if (accept) begin
               s1_addr_q <= bus.cmp_addr_i;
               s1_syn_q  <= syn_in;
            end
            result_valid_q <= s1_valid_q;
            if (s1_valid_q) result_q <= (s1_syn_q == '0);
            if (s2_fail) begin
               fail_q <= 1'b1;
               if (fail_cnt_q != {CNT_W{1'b1}}) fail_cnt_q <= fail_cnt_q + 1'b1;
               if (!first_valid_q) begin
                  first_valid_q <= 1'b1;
                  first_addr_q  <= s1_addr_q;
                  first_syn_q   <= s1_syn_q;
               end
            end
         end
      end
   end

   assign bus.result_o       = result_q;
   assign bus.result_valid_o = result_valid_q;
   assign bus.fail_o         = fail_q;
   assign bus.fail_cnt_o     = fail_cnt_q;
   assign bus.first_valid_o  = first_valid_q;
   assign bus.first_addr_o   = first_addr_q;
   assign bus.first_syn_o    = first_syn_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;

endmodule

// File: tb/tb_mbist_compare_log.sv
// Testbench for mbist_compare_log: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus, checked against a reference model with
// a scoreboard queue of pending compare results.
module tb_mbist_compare_log;

   logic clk_i = 1'b0;
   logic reset_i;

   always #5 clk_i = ~clk_i;

   mbist_compare_log_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) bif ();
   mbist_compare_log_if #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) sif ();

   mbist_compare_log #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .bus(bif.slave));
   mbist_compare_log #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) dut_sat (
      .clk_i(clk_i), .reset_i(reset_i), .bus(sif.slave));

   assign sif.start_i     = bif.start_i;
   assign sif.end_i       = bif.end_i;
   assign sif.cmp_valid_i = bif.cmp_valid_i;
   assign sif.cmp_addr_i  = bif.cmp_addr_i;
   assign sif.data_comp_i = bif.data_comp_i;
   assign sif.exp_data_i  = bif.exp_data_i;
   assign sif.mask_i      = bif.mask_i;

   typedef struct {
      logic       res;
      logic [7:0] addr;
      logic [7:0] syn;
      int         due;
   } sb_t;

   sb_t sbq[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
   int         m_state;
   logic       m_rv, m_res, m_fail, m_fv;
   int         m_cnt, m_cnt2;
   logic [7:0] m_faddr, m_fsyn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input bit rst, input bit st, input bit en, input bit cv,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] e, input logic [7:0] m);
      sb_t it;
      bit  acc;
      reset_i         = rst;
      bif.start_i     = st;
      bif.end_i       = en;
      bif.cmp_valid_i = cv;
      bif.cmp_addr_i  = a;
      bif.data_comp_i = d;
      bif.exp_data_i  = e;
      bif.mask_i      = m;
      acc = !rst && (m_state == 1) && cv && !st;
      if (acc) begin
         it.syn  = (d ^ e) & m;
         it.res  = (it.syn == 8'h00);
         it.addr = a;
         it.due  = cyc + 2;
         sbq.push_back(it);
      end
      @(posedge clk_i);
      #1;
      cyc++;
      m_rv = 1'b0;
      if (rst) begin
         sbq.delete();
         m_state = 0; m_res = 0; m_fail = 0; m_cnt = 0; m_cnt2 = 0;
         m_fv = 0; m_faddr = 0; m_fsyn = 0;
      end else begin
         if (st) begin
            sbq.delete();
            m_fail = 0; m_cnt = 0; m_cnt2 = 0; m_fv = 0; m_faddr = 0; m_fsyn = 0;
         end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            it    = sbq.pop_front();
            m_rv  = 1'b1;
            m_res = it.res;
            if (!it.res) begin
               m_fail = 1'b1;
               if (m_cnt < 255) m_cnt++;
               if (m_cnt2 < 3) m_cnt2++;
               if (!m_fv) begin
                  m_fv = 1'b1; m_faddr = it.addr; m_fsyn = it.syn;
               end
            end
         end
         if (st) m_state = 1;
         else if (m_state == 1 && en) m_state = 2;
         else if (m_state == 2) m_state = 3;
      end
      chk("result_valid", bif.result_valid_o, m_rv);
      chk("result", bif.result_o, m_res);
      chk("fail", bif.fail_o, m_fail);
      chk("fail_cnt", bif.fail_cnt_o, m_cnt);
      chk("first_valid", bif.first_valid_o, m_fv);
      chk("first_addr", bif.first_addr_o, m_faddr);
      chk("first_syn", bif.first_syn_o, m_fsyn);
      chk("busy", bif.busy_o, (m_state == 1 || m_state == 2));
      chk("done", bif.done_o, (m_state == 3));
      chk("sat_fail_cnt", sif.fail_cnt_o, m_cnt2);
      chk("sat_result_valid", sif.result_valid_o, m_rv);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic cmp(input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] e, input logic [7:0] m);
      step(0, 0, 0, 1, a, d, e, m);
   endtask

   initial begin
      m_state = 0; m_rv = 0; m_res = 0; m_fail = 0; m_cnt = 0; m_cnt2 = 0;
      m_fv = 0; m_faddr = 0; m_fsyn = 0;

      // reset state
      step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      step(1, 1, 1, 1, 8'h55, 8'h01, 8'h00, 8'hFF);
      chk("reset_busy_const", bif.busy_o, 1'b0);

      // compares in IDLE are ignored
      cmp(8'h01, 8'hFF, 8'h00, 8'hFF);
      idle(3);

      // pass path: result two edges after the accepting edge
      step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      cmp(8'h00, 8'hA5, 8'hA5, 8'hFF);
      chk("pass_latency_rv_early", bif.result_valid_o, 1'b0);
      idle(1);
      chk("pass_rv", bif.result_valid_o, 1'b1);
      chk("pass_res", bif.result_o, 1'b1);
      idle(1);

      // masked bit, then first fail at 0x11, second fail at 0x12
      cmp(8'h10, 8'h3C, 8'h34, 8'hF7);
      cmp(8'h11, 8'h01, 8'h00, 8'hFF);
      cmp(8'h12, 8'h80, 8'h00, 8'hFF);
      idle(2);
      chk("first_fail_cnt", bif.fail_cnt_o, 32'd2);
      chk("first_fail_addr", bif.first_addr_o, 32'h11);
      chk("first_fail_syn", bif.first_syn_o, 32'h01);

      // all-zero mask always passes
      cmp(8'h20, 8'hFF, 8'h00, 8'h00);
      idle(2);
      chk("mask_zero_res", bif.result_o, 1'b1);

      // saturation on the 2-bit counter instance
      step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) cmp(8'h30 + i[7:0], 8'h0F, 8'hF0, 8'hFF);
      idle(2);
      chk("sat_cnt_final", sif.fail_cnt_o, 32'd3);
      chk("main_cnt_final", bif.fail_cnt_o, 32'd5);

      // failing compare together with end: completes in DRAIN
      step(0, 0, 1, 1, 8'h40, 8'h00, 8'h02, 8'hFF);
      chk("drain_busy", bif.busy_o, 1'b1);
      idle(1);
      chk("end_done", bif.done_o, 1'b1);
      chk("end_rv", bif.result_valid_o, 1'b1);
      chk("end_cnt", bif.fail_cnt_o, 32'd6);
      cmp(8'h41, 8'h00, 8'h02, 8'hFF);
      idle(3);

      // start and end together act as start only
      step(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      idle(1);

      // start one cycle after a failing compare discards it
      cmp(8'h50, 8'h00, 8'hFF, 8'hFF);
      step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      idle(3);
      chk("restart_fail", bif.fail_o, 1'b0);

      // reset in RUN with compares in flight
      cmp(8'h60, 8'h00, 8'hFF, 8'hFF);
      cmp(8'h61, 8'h00, 8'hFF, 8'hFF);
      idle(1);
      step(1, 0, 0, 1, 8'h62, 8'h00, 8'hFF, 8'hFF);
      chk("reset_run_busy", bif.busy_o, 1'b0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mbist_compare_log.md
MBIST_COMPARE_LOG -- requirements
Module: mbist_compare_log

Interface
REQ-001 Parameter DATA_W, default 8, width of read data, expected data and mask.
REQ-002 Parameter ADDR_W, default 8, width of compared-word address.
REQ-003 Parameter CNT_W, default 8, width of fail counter.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 START  input  1  pulse: clear log, enter RUN.
REQ-007 END  input  1  pulse: close session.
REQ-008 CMP_VALID  input  1  compare request this cycle.
REQ-009 CMP_ADDR  input  ADDR_W  address of the word being compared.
REQ-010 DATA_comp  input  DATA_W  data read from SRAM.
REQ-011 ExpDATA  input  DATA_W  expected data.
REQ-012 MASK  input  DATA_W  per-bit compare enable; 1 = compare.
REQ-013 RESULT  output  1  per-compare pass (1) / fail (0), qualified by RESULT_VALID.
REQ-014 RESULT_VALID  output  1  one-cycle strobe per accepted compare.
REQ-015 FAIL  output  1  sticky session fail flag.
REQ-016 FAIL_CNT  output  CNT_W  saturating count of failing compares.
REQ-017 FIRST_VALID  output  1  first-fail record is held.
REQ-018 FIRST_ADDR  output  ADDR_W  address of the first failing compare.
REQ-019 FIRST_SYN  output  DATA_W  masked XOR syndrome of the first failing compare.
REQ-020 BUSY  output  1  high in RUN and DRAIN.
REQ-021 DONE  output  1  high in DONE.

Function
REQ-022 The state machine SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-023 Transitions: START=1 in any state -> RUN; RUN with END=1 and START=0 -> DRAIN; DRAIN -> DONE unconditionally; IDLE and DONE otherwise hold.
REQ-024 A compare SHALL be accepted only when state=RUN, CMP_VALID=1 and START=0, including the cycle END=1.
REQ-025 CMP_VALID outside accepted conditions SHALL be ignored, with no effect on outputs.
REQ-026 Stage 1 SHALL register s1_valid, s1_addr and s1_syn = (DATA_comp XOR ExpDATA) AND MASK at the accepting edge.
REQ-027 Stage 2 SHALL, at the next edge with s1_valid=1, set RESULT = (s1_syn == 0) and RESULT_VALID = 1; otherwise RESULT_VALID = 0 and RESULT holds.
REQ-028 Latency from the accepting edge to RESULT_VALID visible SHALL be exactly 2 edges; back-to-back compares every cycle SHALL be supported at full throughput.
REQ-029 On a stage-2 fail, FAIL SHALL be set and FAIL_CNT SHALL increment, saturating at 2^CNT_W-1 without wrap.
REQ-030 On a stage-2 fail with FIRST_VALID=0, FIRST_ADDR, FIRST_SYN and FIRST_VALID=1 SHALL be captured; later fails SHALL NOT overwrite them.
REQ-031 MASK all-zero SHALL make every compare pass.
REQ-032 START SHALL clear FAIL, FAIL_CNT, FIRST_VALID, FIRST_ADDR, FIRST_SYN, RESULT_VALID and s1_valid at that edge, discarding any in-flight compare.
REQ-033 START and END in the same cycle SHALL be treated as START only.
REQ-034 A compare accepted together with END SHALL complete in DRAIN; its RESULT_VALID and DONE SHALL become visible at the same edge.
REQ-035 FAIL, FAIL_CNT and FIRST_* SHALL hold their values in DONE and IDLE until the next START or RESET.

Reset
REQ-036 With RESET=1 at a rising edge: state = IDLE, s1_valid = 0, RESULT = 0, RESULT_VALID = 0, FAIL = 0, FAIL_CNT = 0, FIRST_VALID = 0, FIRST_ADDR = 0, FIRST_SYN = 0, BUSY = 0, DONE = 0.
REQ-037 RESET SHALL take priority over START, END and CMP_VALID and SHALL abort any session mid-operation.

Verification
REQ-038 Pass path: START, then compare DATA_comp=0xA5, ExpDATA=0xA5, MASK=0xFF -> RESULT_VALID and RESULT=1 two edges later; FAIL=0; FAIL_CNT=0.
REQ-039 Mask/first-fail: compares (addr 0x10, 0x3C vs 0x34, MASK 0xF7), then (addr 0x11, 0x01 vs 0x00, MASK 0xFF), then (addr 0x12, 0x80 vs 0x00, MASK 0xFF) -> results 1,0,0; FAIL_CNT=2; FIRST_ADDR=0x11; FIRST_SYN=0x01.
REQ-040 Saturation: with CNT_W=2, five consecutive failing compares -> FAIL_CNT sequence 1,2,3,3,3 with no wrap.
REQ-041 END with compare: END asserted in the same cycle as a failing compare -> BUSY high for DRAIN; DONE=1 and RESULT_VALID=1 with RESULT=0 at the same edge; FAIL_CNT includes that fail.
REQ-042 Restart/reset: START issued one cycle after a failing compare is accepted -> no RESULT_VALID for that compare, and FAIL=0, FAIL_CNT=0; RESET asserted in RUN -> all outputs return to REQ-036 values at that edge.
